// File: rtl/msp430_pkg.sv
// Shared constants, FSM encoding and vector helper for the interrupt controller.
package msp430_pkg;

    localparam logic [15:0] IRQ_VEC_BASE = 16'hFFE0;
    localparam logic [3:0]  NMI_ID       = 4'd14;
    localparam logic [15:0] NMI_VEC      = 16'hFFFC;
    localparam logic [15:0] RST_VEC_ADDR = 16'hFFFE;

    typedef enum logic [1:0] {
        IRQ_IDLE    = 2'd0,
        IRQ_REQ     = 2'd1,
        IRQ_SERVICE = 2'd2
    } irq_state_t;

    // Vector table slot for a source id; the table is word-aligned.
    function automatic logic [15:0] irq_vector(input logic [3:0] id);
        return IRQ_VEC_BASE + {11'd0, id, 1'b0};
    endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// Fixed-priority encoder: NMI first, then the highest-index eligible maskable line.
module irq_prio_enc
    import msp430_pkg::*;
#(
    parameter int NUM_IRQ = 14
) (
    input  logic [NUM_IRQ-1:0] elig,
    input  logic               nmi,
    output logic               valid,
    output logic [3:0]         id
);

    always_comb begin
        valid = nmi | (|elig);
        id    = 4'd0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            if (elig[i]) begin
                id = 4'(i);
            end
        end
        if (nmi) begin
            id = NMI_ID;
        end
    end

endmodule

// File: rtl/irq_ctrl.sv
// Interrupt controller: edge capture, pending flags, fixed-priority arbitration and
// a request/ack/reti handshake with the core.
module irq_ctrl
    import msp430_pkg::*;
#(
    parameter int NUM_IRQ = 14
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_IRQ-1:0] irq_in,
    input  logic [NUM_IRQ-1:0] irq_en,
    input  logic               nmi_in,
    input  logic               gie,
    input  logic               irq_ack,
    input  logic               reti,
    output logic               irq_req,
    output logic [15:0]        irq_vec,
    output logic [3:0]         irq_id,
    output logic [NUM_IRQ-1:0] irq_pend,
    output logic               in_service
);

    irq_state_t         state, state_nxt;
    logic [NUM_IRQ-1:0] irq_d, pend, pend_nxt, rise, elig, sel, clr_mask;
    logic               nmi_d, nmi_pend, nmi_pend_nxt, nmi_rise;
    logic               armed;
    logic [3:0]         id_q, id_nxt, enc_id;
    logic [15:0]        vec_q, vec_nxt;
    logic               enc_valid, clr_en, cur_nmi, cur_elig;

    // Edge detection is held off for the first cycle after reset so that a line
    // already high at release is absorbed into the delay flop, not seen as an edge.
    assign rise     = armed ? (irq_in & ~irq_d) : '0;
    assign nmi_rise = armed & nmi_in & ~nmi_d;

    assign elig     = pend & irq_en & {NUM_IRQ{gie}};
    assign sel      = NUM_IRQ'(1) << id_q;
    assign cur_nmi  = (id_q == NMI_ID);
    assign cur_elig = |(elig & sel);

    // Set wins over the ack-driven clear.
    assign clr_mask     = (clr_en && !cur_nmi) ? sel : '0;
    assign pend_nxt     = (pend & ~clr_mask) | rise;
    assign nmi_pend_nxt = (nmi_pend & ~(clr_en & cur_nmi)) | nmi_rise;

    irq_prio_enc #(
        .NUM_IRQ (NUM_IRQ)
    ) u_prio_enc (
        .elig  (elig),
        .nmi   (nmi_pend),
        .valid (enc_valid),
        .id    (enc_id)
    );

    always_comb begin
        state_nxt = state;
        id_nxt    = id_q;
        vec_nxt   = vec_q;
        clr_en    = 1'b0;
        case (state)
            IRQ_IDLE: begin
                if (enc_valid) begin
                    state_nxt = IRQ_REQ;
                    id_nxt    = enc_id;
                    vec_nxt   = irq_vector(enc_id);
                end
            end
            IRQ_REQ: begin
                if (irq_ack) begin
                    state_nxt = IRQ_SERVICE;
                    clr_en    = 1'b1;
                end else if (!cur_nmi && nmi_pend) begin
                    id_nxt  = NMI_ID;
                    vec_nxt = NMI_VEC;
                end else if (!cur_nmi && !cur_elig) begin
                    state_nxt = IRQ_IDLE;
                end
            end
            IRQ_SERVICE: begin
                if (reti) begin
                    state_nxt = IRQ_IDLE;
                end
            end
            default: state_nxt = IRQ_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            irq_d    <= '0;
            nmi_d    <= 1'b0;
            armed    <= 1'b0;
            pend     <= '0;
            nmi_pend <= 1'b0;
            state    <= IRQ_IDLE;
            id_q     <= 4'd0;
            vec_q    <= IRQ_VEC_BASE;
        end else begin
            irq_d    <= irq_in;
            nmi_d    <= nmi_in;
            armed    <= 1'b1;
            pend     <= pend_nxt;
            nmi_pend <= nmi_pend_nxt;
            state    <= state_nxt;
            id_q     <= id_nxt;
            vec_q    <= vec_nxt;
        end
    end

    assign irq_req    = (state == IRQ_REQ);
    assign in_service = (state == IRQ_SERVICE);
    assign irq_vec    = vec_q;
    assign irq_id     = id_q;
    assign irq_pend   = pend;

endmodule
